// File: rtl/grf_wb_sink.sv
// grf_wb_sink: general register file acting as the write-back sink.
//   - 2**AW registers of DW bits, register 0 hardwired to zero
//   - two combinational read ports with same-cycle write-to-read bypass
//   - handshaked dump port streaming every register, one per beat
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ra1/ra2 -> rd1/rd2    combinational read ports (rs / rt)
//   we, wa, wd            write port (destination mux / write-data mux)
//   dump_start            pulse to begin a dump, honoured only when idle
//   dump_valid/dump_ready beat handshake
//   dump_idx/dump_data    index and live (bypassed) contents of current beat
//   dump_busy             high while scanning and in the done cycle
//   dump_done             one-cycle pulse after the last beat is accepted
module grf_wb_sink #(
   parameter int unsigned DW = 32,
   parameter int unsigned AW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic          dump_start,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [AW-1:0] dump_idx,
   output logic [DW-1:0] dump_data,
   output logic          dump_busy,
   output logic          dump_done
);

   localparam int unsigned NREG = 2**AW;
   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [DW-1:0] regs [NREG];

   // Register storage; entry 0 is never written so it stays zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   // Read port 1 with zero-latency bypass of the write in flight.
   always_comb begin
      rd1 = regs[ra1];
      if (ra1 == '0) begin
         rd1 = '0;
      end else if (we && (wa == ra1)) begin
         rd1 = wd;
      end
   end

   // Read port 2, same rule as port 1.
   always_comb begin
      rd2 = regs[ra2];
      if (ra2 == '0) begin
         rd2 = '0;
      end else if (we && (wa == ra2)) begin
         rd2 = wd;
      end
   end

   // Dump data tracks live contents, so a stalled beat picks up writes.
   always_comb begin
      dump_data = regs[dump_idx];
      if (dump_idx == '0) begin
         dump_data = '0;
      end else if (we && (wa == dump_idx)) begin
         dump_data = wd;
      end
   end

   // Dump sequencer; flags are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dump_idx   <= '0;
         dump_valid <= 1'b0;
         dump_busy  <= 1'b0;
         dump_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               dump_done <= 1'b0;
               if (dump_start) begin
                  state      <= SCAN;
                  dump_idx   <= '0;
                  dump_valid <= 1'b1;
                  dump_busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (dump_ready) begin
                  // The last beat always exits; the index never wraps.
                  if (dump_idx == LAST_IDX) begin
                     state      <= DONE;
                     dump_valid <= 1'b0;
                     dump_done  <= 1'b1;
                  end else begin
                     dump_idx <= dump_idx + AW'(1);
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               dump_idx  <= '0;
               dump_busy <= 1'b0;
               dump_done <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               dump_idx   <= '0;
               dump_valid <= 1'b0;
               dump_busy  <= 1'b0;
               dump_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
